tag_ct_arbiter: RTL and testbench
=================================

TAG_CT_ARBITER -- requirements
Module: tag_ct_arbiter

Interface
REQ-001 SHALL have parameter NTAG, default 11: tag field width.
REQ-002 SHALL have parameter NCT, default 9: count field width.
REQ-003 SHALL have parameter NCNT, default 16: per-input grant counter width.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports in0_tag / in1_tag, input, NTAG: tag from requester 0 (tag-split path) / requester 1 (host-injected path).
REQ-007 SHALL have ports in0_ct / in1_ct, input, NCT: count from requester 0 / 1.
REQ-008 SHALL have ports in0_v / in1_v, input, 1: requester data valid.
REQ-009 SHALL have ports in0_a / in1_a, output, 1: requester data accepted.
REQ-010 SHALL have ports out_tag (NTAG), out_ct (NCT), out_v (1), all outputs: merged tag/count channel.
REQ-011 SHALL have port out_a, input, 1: downstream accept.
REQ-012 SHALL have port conf_en, input, 2: per-requester enable; bit i gates requester i.
REQ-013 SHALL have ports grant_cnt0 / grant_cnt1, output, NCNT: accepted-word count per requester.

Function
REQ-014 SHALL complete a transfer on any channel in a cycle where its v and a are both 1 at the rising clk edge.
REQ-015 SHALL hold output in a one-entry register (out_tag, out_ct, out_v); out_v rises the cycle after an input transfer (latency 1).
REQ-016 SHALL treat the register as free when out_v=0 or (out_v=1 and out_a=1); free register permits an input transfer the same cycle (full throughput, one word/cycle).
REQ-017 SHALL treat requester i as eligible when in{i}_v=1 and conf_en[i]=1; ineligible requester SHALL see in{i}_a=0.
REQ-018 SHALL assert at most one of in0_a/in1_a per cycle; in{i}_a is combinational on eligibility, last_grant, and register-free status.
REQ-019 SHALL arbitrate round-robin: one eligible -> it wins; both eligible -> requester not equal to last_grant wins.
REQ-020 SHALL update last_grant only on an input transfer, to the transferring requester.
REQ-021 SHALL keep out_tag/out_ct stable while out_v=1 and out_a=0.
REQ-022 SHALL drop out_v to 0 after an output transfer with no simultaneous input transfer.
REQ-023 SHALL increment grant_cnt{i} by 1 per requester-i transfer, wrapping from 2^NCNT-1 to 0.
REQ-024 SHALL, if conf_en[i] deasserts while in{i}_v=1, hold in{i}_a=0 without data loss; a word already in the output register SHALL still drain.

Reset
REQ-025 SHALL, while reset=0, force out_v=0, out_tag=0, out_ct=0, grant_cnt0=0, grant_cnt1=0, last_grant=1 (requester 0 wins first contest), asynchronously.
REQ-026 SHALL discard any held output word on reset mid-operation; first word after reset release follows REQ-019.

Configuration
REQ-027 SHALL compile tag coalescing in when TAG_CT_ARBITER_COALESCE_EN is defined.
REQ-028 With TAG_CT_ARBITER_COALESCE_EN: when out_v=1, out_a=0, winner tag==out_tag, and out_ct+winner ct <= 2^NCT-1, SHALL accept the winner word and set out_ct to the sum (tag unchanged); the accept counts as a transfer for REQ-020/REQ-023.
REQ-029 With TAG_CT_ARBITER_COALESCE_EN: a sum exceeding 2^NCT-1 or a tag mismatch SHALL not merge; requester waits (a=0).
REQ-030 Without TAG_CT_ARBITER_COALESCE_EN: a held word (out_v=1, out_a=0) SHALL block all input accepts.

Verification
REQ-031 Reset release, conf_en=2'b11, both v=1 continuously, out_a=1 -> grants alternate 0,1,0,1 starting with in0; one out word per cycle; grant_cnt0=grant_cnt1=50 after 100 cycles.
REQ-032 conf_en=2'b01, in1_v=1 held, in0 idle -> in1_a=0 forever, out_v=0, grant_cnt1=0; set conf_en=2'b11 -> in1 word (tag 0x123, ct 5) appears at out next cycle.
REQ-033 out_a=0 for 10 cycles with in0 valid (tag 0x7, ct 3) -> out_tag=0x7/out_ct=3 stable, in0_a=0 (macro off); out_a=1 -> word drains, next accepted same cycle.
REQ-034 Macro on, out held tag 0x7 ct 3, in0 tag 0x7 ct 4 -> out_ct=7, grant_cnt0+1; in0 tag 0x7 ct 510 with out_ct=7 -> no merge, in0_a=0.
REQ-035 grant_cnt0 preloaded by 65535 transfers, one more in0 transfer -> grant_cnt0=0.
REQ-036 Reset asserted with out_v=1 and out_a=0 -> out_v=0 immediately, counters 0; after release in0 wins first tie.

Source files
------------

// File: rtl/tag_ct_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tag_ct_arbiter
// Purpose : Round-robin merge of two tag/count requesters into one registered
//           output word. Optional same-tag coalescing: TAG_CT_ARBITER_COALESCE_EN
// Revision: 1.0
// ============================================================================
module tag_ct_arbiter #(
  parameter int NTAG = 11,
  parameter int NCT  = 9,
  parameter int NCNT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NTAG-1:0] in0_tag,
  input  logic [NCT-1:0]  in0_ct,
  input  logic            in0_v,
  output logic            in0_a,
  input  logic [NTAG-1:0] in1_tag,
  input  logic [NCT-1:0]  in1_ct,
  input  logic            in1_v,
  output logic            in1_a,
  output logic [NTAG-1:0] out_tag,
  output logic [NCT-1:0]  out_ct,
  output logic            out_v,
  input  logic            out_a,
  input  logic [1:0]      conf_en,
  output logic [NCNT-1:0] grant_cnt0,
  output logic [NCNT-1:0] grant_cnt1
);

  logic            out_v_q, out_v_d;
  logic [NTAG-1:0] out_tag_q, out_tag_d;
  logic [NCT-1:0]  out_ct_q, out_ct_d;
  logic            last_grant_q, last_grant_d;
  logic [NCNT-1:0] cnt0_q, cnt0_d;
  logic [NCNT-1:0] cnt1_q, cnt1_d;

  logic            elig0, elig1, win1, any_elig, reg_free, merge_ok, accept;
  logic [NTAG-1:0] win_tag;
  logic [NCT-1:0]  win_ct;

`ifdef TAG_CT_ARBITER_COALESCE_EN
  logic [NCT:0]    ct_sum;
  assign ct_sum   = {1'b0, out_ct_q} + {1'b0, win_ct};
  // Merge only into a stalled word with the same tag, and only if the sum fits.
  assign merge_ok = out_v_q & ~out_a & (win_tag == out_tag_q) & ~ct_sum[NCT];
`else
  assign merge_ok = 1'b0;
`endif

  always_comb begin
    elig0    = in0_v & conf_en[0];
    elig1    = in1_v & conf_en[1];
    any_elig = elig0 | elig1;
    // On a tie the requester that did not win last time gets the grant.
    win1     = elig1 & (~elig0 | ~last_grant_q);
    win_tag  = win1 ? in1_tag : in0_tag;
    win_ct   = win1 ? in1_ct  : in0_ct;
    reg_free = ~out_v_q | out_a;
    accept   = any_elig & (reg_free | merge_ok);
    in0_a    = accept & ~win1;
    in1_a    = accept & win1;
  end

  always_comb begin
    out_v_d      = out_v_q;
    out_tag_d    = out_tag_q;
    out_ct_d     = out_ct_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q + {{(NCNT-1){1'b0}}, in0_a};
    cnt1_d       = cnt1_q + {{(NCNT-1){1'b0}}, in1_a};
    if (accept) begin
      last_grant_d = win1;
      if (reg_free) begin
        out_v_d   = 1'b1;
        out_tag_d = win_tag;
        out_ct_d  = win_ct;
      end else begin
        out_ct_d  = out_ct_q + win_ct;
      end
    end else if (out_v_q && out_a) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v_q      <= 1'b0;
      out_tag_q    <= '0;
      out_ct_q     <= '0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      out_v_q      <= out_v_d;
      out_tag_q    <= out_tag_d;
      out_ct_q     <= out_ct_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign out_v      = out_v_q;
  assign out_tag    = out_tag_q;
  assign out_ct     = out_ct_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_tag_ct_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_tag_ct_arbiter
// Purpose : Directed scoreboard bench for tag_ct_arbiter
// Revision: 1.0
// ============================================================================
module tb_tag_ct_arbiter;

  localparam int NTAG = 11;
  localparam int NCT  = 9;
  localparam int NCNT = 16;

  typedef struct packed {
    logic [NTAG-1:0] tag;
    logic [NCT-1:0]  ct;
  } word_t;

  logic            clk, reset;
  logic [NTAG-1:0] in0_tag, in1_tag, out_tag;
  logic [NCT-1:0]  in0_ct, in1_ct, out_ct;
  logic            in0_v, in1_v, in0_a, in1_a, out_v, out_a;
  logic [1:0]      conf_en;
  logic [NCNT-1:0] grant_cnt0, grant_cnt1;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];

  tag_ct_arbiter #(.NTAG(NTAG), .NCT(NCT), .NCNT(NCNT)) dut (
    .clk(clk), .reset(reset),
    .in0_tag(in0_tag), .in0_ct(in0_ct), .in0_v(in0_v), .in0_a(in0_a),
    .in1_tag(in1_tag), .in1_ct(in1_ct), .in1_v(in1_v), .in1_a(in1_a),
    .out_tag(out_tag), .out_ct(out_ct), .out_v(out_v), .out_a(out_a),
    .conf_en(conf_en), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic push(input logic [NTAG-1:0] t, input logic [NCT-1:0] c);
    word_t w;
    w.tag = t;
    w.ct  = c;
    exp_q.push_back(w);
  endtask

  task automatic drain(input string name);
    repeat (3) tick();
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: every completed output transfer is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset && out_v && out_a) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%0h/%0h required=none", out_tag, out_ct);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        if (out_tag !== e.tag || out_ct !== e.ct) begin
          errors++;
          $display("FAIL sb_word actual=%0h/%0h required=%0h/%0h t=%0t",
                   out_tag, out_ct, e.tag, e.ct, $time);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; conf_en = 2'b00; out_a = 1'b0;
    in0_v = 1'b0; in0_tag = '0; in0_ct = '0;
    in1_v = 1'b0; in1_tag = '0; in1_ct = '0;

    // Reset values
    at_neg();
    chk("rst_out_v", out_v, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_ct", out_ct, 0);
    chk("rst_cnt0", grant_cnt0, 0);
    chk("rst_cnt1", grant_cnt1, 0);

    // Alternating grants under continuous contention
    conf_en = 2'b11; out_a = 1'b1;
    in0_v = 1'b1; in0_tag = 11'h0A0; in0_ct = 9'd1;
    in1_v = 1'b1; in1_tag = 11'h1B1; in1_ct = 9'd2;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) push(11'h0A0, 9'd1);
      else            push(11'h1B1, 9'd2);
    end
    for (int i = 0; i < 100; i++) begin
      at_neg();
      chk("rr_in0_a", in0_a, (i % 2 == 0) ? 1 : 0);
      chk("rr_in1_a", in1_a, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    in0_v = 1'b0; in1_v = 1'b0;
    at_neg();
    chk("rr_cnt0", grant_cnt0, 50);
    chk("rr_cnt1", grant_cnt1, 50);
    drain("rr");

    // Disabled requester is never accepted, then enabled
    do_reset();
    conf_en = 2'b01; out_a = 1'b1;
    in1_v = 1'b1; in1_tag = 11'h123; in1_ct = 9'd5;
    repeat (5) begin
      at_neg();
      chk("dis_in1_a", in1_a, 0);
      chk("dis_out_v", out_v, 0);
      chk("dis_cnt1", grant_cnt1, 0);
      tick();
    end
    conf_en = 2'b11;
    push(11'h123, 9'd5);
    at_neg();
    chk("en_in1_a", in1_a, 1);
    tick();
    in1_v = 1'b0;
    at_neg();
    chk("en_out_v", out_v, 1);
    chk("en_cnt1", grant_cnt1, 1);
    drain("en");

    // Held output with downstream stall, then drain plus same-cycle accept
    do_reset();
    conf_en = 2'b11; out_a = 1'b0;
    in0_v = 1'b1; in0_tag = 11'h007; in0_ct = 9'd3;
    push(11'h007, 9'd3);
    at_neg();
    chk("hold_first_a", in0_a, 1);
    tick();
    in0_tag = 11'h008; in0_ct = 9'd4;
    repeat (10) begin
      at_neg();
      chk("hold_out_v", out_v, 1);
      chk("hold_out_tag", out_tag, 11'h007);
      chk("hold_out_ct", out_ct, 3);
      chk("hold_in0_a", in0_a, 0);
      tick();
    end
    out_a = 1'b1;
    push(11'h008, 9'd4);
    at_neg();
    chk("drain_in0_a", in0_a, 1);
    tick();
    in0_v = 1'b0;
    drain("hold");

`ifdef TAG_CT_ARBITER_COALESCE_EN
    // Coalescing into a stalled word, and overflow refusal
    do_reset();
    conf_en = 2'b11; out_a = 1'b0;
    in0_v = 1'b1; in0_tag = 11'h007; in0_ct = 9'd3;
    push(11'h007, 9'd7);
    at_neg();
    chk("co_first_a", in0_a, 1);
    tick();
    in0_ct = 9'd4;
    at_neg();
    chk("co_merge_a", in0_a, 1);
    tick();
    in0_ct = 9'd510;
    at_neg();
    chk("co_sum_ct", out_ct, 7);
    chk("co_cnt0", grant_cnt0, 2);
    chk("co_ovf_a", in0_a, 0);
    tick();
    at_neg();
    chk("co_ovf_ct", out_ct, 7);
    out_a = 1'b1;
    push(11'h007, 9'd510);
    #1;
    chk("co_drain_a", in0_a, 1);
    tick();
    in0_v = 1'b0;
    drain("co");
`endif

    // Grant counter wrap
    do_reset();
    conf_en = 2'b01; out_a = 1'b1;
    in0_v = 1'b1; in0_tag = 11'h055; in0_ct = 9'd1;
    for (int i = 0; i < 65536; i++) push(11'h055, 9'd1);
    repeat (65535) tick();
    at_neg();
    chk("wrap_cnt0_max", grant_cnt0, 16'hFFFF);
    tick();
    in0_v = 1'b0;
    at_neg();
    chk("wrap_cnt0_zero", grant_cnt0, 0);
    drain("wrap");

    // Reset while a word is held, then first tie after release
    do_reset();
    conf_en = 2'b11; out_a = 1'b0;
    in0_v = 1'b1; in0_tag = 11'h0A0; in0_ct = 9'd1;
    push(11'h0A0, 9'd1);
    at_neg();
    chk("mr_first_a", in0_a, 1);
    tick();
    in0_v = 1'b0;
    at_neg();
    chk("mr_out_v_held", out_v, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_out_v", out_v, 0);
    chk("mr_out_tag", out_tag, 0);
    chk("mr_cnt0", grant_cnt0, 0);
    void'(exp_q.pop_front());
    in0_v = 1'b1; in0_tag = 11'h0A0; in0_ct = 9'd1;
    in1_v = 1'b1; in1_tag = 11'h1B1; in1_ct = 9'd2;
    out_a = 1'b1;
    tick();
    reset = 1'b1;
    push(11'h0A0, 9'd1);
    at_neg();
    chk("mr_tie_in0_a", in0_a, 1);
    chk("mr_tie_in1_a", in1_a, 0);
    tick();
    in0_v = 1'b0; in1_v = 1'b0;
    drain("mr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
